// File: rtl/ocm_dualport_if.sv
// Request/response bundle between a dual-port on-chip memory and its two requesters.
// Latency: n/a (wires only).
// Backpressure: each response channel is valid/ready; req_ready is driven by the memory side.
interface ocm_dualport_if #(
    parameter int XLEN = 32
);
    logic              i_req_valid_i;
    logic              i_req_ready_o;
    logic [XLEN-1:0]   i_addr_i;
    logic              i_rsp_valid_o;
    logic              i_rsp_ready_i;
    logic [XLEN-1:0]   i_rsp_data_o;
    logic              i_rsp_err_o;

    logic              d_req_valid_i;
    logic              d_req_ready_o;
    logic [XLEN-1:0]   d_addr_i;
    logic              d_we_i;
    logic [XLEN/8-1:0] d_be_i;
    logic [XLEN-1:0]   d_wdata_i;
    logic              d_rsp_valid_o;
    logic              d_rsp_ready_i;
    logic [XLEN-1:0]   d_rsp_rdata_o;
    logic              d_rsp_err_o;

    modport slave (
        input  i_req_valid_i, i_addr_i, i_rsp_ready_i,
        input  d_req_valid_i, d_addr_i, d_we_i, d_be_i, d_wdata_i, d_rsp_ready_i,
        output i_req_ready_o, i_rsp_valid_o, i_rsp_data_o, i_rsp_err_o,
        output d_req_ready_o, d_rsp_valid_o, d_rsp_rdata_o, d_rsp_err_o
    );

    modport master (
        output i_req_valid_i, i_addr_i, i_rsp_ready_i,
        output d_req_valid_i, d_addr_i, d_we_i, d_be_i, d_wdata_i, d_rsp_ready_i,
        input  i_req_ready_o, i_rsp_valid_o, i_rsp_data_o, i_rsp_err_o,
        input  d_req_ready_o, d_rsp_valid_o, d_rsp_rdata_o, d_rsp_err_o
    );
endinterface

// File: rtl/ocm_dualport.sv
// Dual-port on-chip memory: read-only instruction port, byte-enabled read/write data port.
// Latency: 1 cycle request-to-response per port, one request per cycle sustained.
// Backpressure: one-entry response register per port; req_ready = !rsp_valid | rsp_ready.
module ocm_dualport #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4096,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    ocm_dualport_if.slave  bus
);
    localparam int BYTES = XLEN / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0] dat;
        logic            err;
    } rsp_t;

    logic [XLEN-1:0] mem [DEPTH];

    logic [XLEN-1:0] i_rel, d_rel;
    logic [IDXW-1:0] i_idx, d_idx;
    logic            i_fault, d_fault;
    logic            i_acc, d_acc, d_wr;
    logic            i_vld_q, d_vld_q;
    rsp_t            i_rsp_q, d_rsp_q;
    logic [XLEN-1:0] wmask, wr_word;

    // Index is taken after modular rebasing, so addresses below BASE_ADDR wrap high and fault.
    assign i_rel   = bus.i_addr_i - BASE_ADDR;
    assign d_rel   = bus.d_addr_i - BASE_ADDR;
    assign i_idx   = i_rel[OFF +: IDXW];
    assign d_idx   = d_rel[OFF +: IDXW];
    assign i_fault = (bus.i_addr_i[OFF-1:0] != '0) || ((i_rel >> OFF) >= XLEN'(DEPTH));
    assign d_fault = (bus.d_addr_i[OFF-1:0] != '0) || ((d_rel >> OFF) >= XLEN'(DEPTH));

    assign bus.i_req_ready_o = !i_vld_q || bus.i_rsp_ready_i;
    assign bus.d_req_ready_o = !d_vld_q || bus.d_rsp_ready_i;
    assign i_acc = bus.i_req_valid_i && bus.i_req_ready_o;
    assign d_acc = bus.d_req_valid_i && bus.d_req_ready_o;
    assign d_wr  = d_acc && bus.d_we_i && !d_fault && !rst_i;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < BYTES; b++) begin
            wmask[b*8 +: 8] = {8{bus.d_be_i[b]}};
        end
    end
    assign wr_word = (mem[d_idx] & ~wmask) | (bus.d_wdata_i & wmask);

    // Reads below sample mem before this edge's write lands: read-first on collisions.
    always_ff @(posedge clk_i) begin
        if (d_wr) begin
            mem[d_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_vld_q <= 1'b0;
            i_rsp_q <= '0;
        end else if (i_acc) begin
            i_vld_q     <= 1'b1;
            i_rsp_q.err <= i_fault;
            i_rsp_q.dat <= i_fault ? '0 : mem[i_idx];
        end else if (bus.i_rsp_ready_i) begin
            i_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_vld_q <= 1'b0;
            d_rsp_q <= '0;
        end else if (d_acc) begin
            d_vld_q     <= 1'b1;
            d_rsp_q.err <= d_fault;
            d_rsp_q.dat <= (d_fault || bus.d_we_i) ? '0 : mem[d_idx];
        end else if (bus.d_rsp_ready_i) begin
            d_vld_q <= 1'b0;
        end
    end

    assign bus.i_rsp_valid_o = i_vld_q;
    assign bus.i_rsp_data_o  = i_rsp_q.dat;
    assign bus.i_rsp_err_o   = i_rsp_q.err;
    assign bus.d_rsp_valid_o = d_vld_q;
    assign bus.d_rsp_rdata_o = d_rsp_q.dat;
    assign bus.d_rsp_err_o   = d_rsp_q.err;
endmodule

// File: tb/tb_ocm_dualport.sv
// Bench for ocm_dualport: table of directed data-port vectors, hand sequences for
// collisions, stalls, streaming and reset, then random traffic against an array model.
module tb_ocm_dualport;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4096;

    logic clk_i = 1'b0;
    logic rst_i;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk_i = ~clk_i;

    ocm_dualport_if #(.XLEN(XLEN)) bus ();

    ocm_dualport #(.XLEN(XLEN), .DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    vec_t        tbl [17];
    logic [31:0] mdl [DEPTH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic d_txn(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input string nm);
        bus.d_req_valid_i = 1'b1;
        bus.d_we_i        = we;
        bus.d_addr_i      = a;
        bus.d_be_i        = be;
        bus.d_wdata_i     = wd;
        #1;
        chk({nm, " d_req_ready"}, 32'(bus.d_req_ready_o), 32'd1);
        step();
        bus.d_req_valid_i = 1'b0;
        chk({nm, " d_rsp_valid"}, 32'(bus.d_rsp_valid_o), 32'd1);
        chk({nm, " d_rdata"}, bus.d_rsp_rdata_o, exp_rd);
        chk({nm, " d_err"}, 32'(bus.d_rsp_err_o), 32'(exp_err));
    endtask

    task automatic i_txn(input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_err,
                         input string nm);
        bus.i_req_valid_i = 1'b1;
        bus.i_addr_i      = a;
        step();
        bus.i_req_valid_i = 1'b0;
        chk({nm, " i_rsp_valid"}, 32'(bus.i_rsp_valid_o), 32'd1);
        chk({nm, " i_data"}, bus.i_rsp_data_o, exp_rd);
        chk({nm, " i_err"}, 32'(bus.i_rsp_err_o), 32'(exp_err));
    endtask

    function automatic logic is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        int kind, idx;
        kind = $urandom_range(0, 15);
        idx  = $urandom_range(0, 15);
        if (kind == 0) return 32'(idx * 4 + $urandom_range(1, 3));
        if (kind == 1) return 32'(32'h4000 + idx * 4);
        return 32'(idx * 4);
    endfunction

    initial begin
        tbl[0]  = '{1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0100, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0104, 4'hF, 32'h1122_3344, 32'h0,         1'b0};
        tbl[3]  = '{1'b1, 32'h0000_0104, 4'h5, 32'hAABB_CCDD, 32'h0,         1'b0};
        tbl[4]  = '{1'b0, 32'h0000_0104, 4'h0, 32'h0,         32'h11BB_33DD, 1'b0};
        tbl[5]  = '{1'b0, 32'h0000_0102, 4'h0, 32'h0,         32'h0,         1'b1};
        tbl[6]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h0000_0055, 32'h0,         1'b0};
        tbl[7]  = '{1'b1, 32'h0000_4000, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b1};
        tbl[8]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0000_0055, 1'b0};
        tbl[9]  = '{1'b1, 32'h0000_0108, 4'hF, 32'h1234_5678, 32'h0,         1'b0};
        tbl[10] = '{1'b1, 32'h0000_0108, 4'h0, 32'hFFFF_FFFF, 32'h0,         1'b0};
        tbl[11] = '{1'b0, 32'h0000_0108, 4'h0, 32'h0,         32'h1234_5678, 1'b0};
        tbl[12] = '{1'b1, 32'h0000_3FFC, 4'hF, 32'h0BAD_F00D, 32'h0,         1'b0};
        tbl[13] = '{1'b0, 32'h0000_3FFC, 4'h0, 32'h0,         32'h0BAD_F00D, 1'b0};
        tbl[14] = '{1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,         32'h0,         1'b1};
        tbl[15] = '{1'b1, 32'h0000_0103, 4'hF, 32'h0000_0001, 32'h0,         1'b1};
        tbl[16] = '{1'b0, 32'h0000_0100, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b0};

        rst_i = 1'b1;
        bus.i_req_valid_i = 1'b0; bus.i_addr_i = '0; bus.i_rsp_ready_i = 1'b1;
        bus.d_req_valid_i = 1'b0; bus.d_addr_i = '0; bus.d_we_i = 1'b0;
        bus.d_be_i = '0; bus.d_wdata_i = '0; bus.d_rsp_ready_i = 1'b1;
        step(); step();
        chk("rst i_rsp_valid", 32'(bus.i_rsp_valid_o), 32'd0);
        chk("rst d_rsp_valid", 32'(bus.d_rsp_valid_o), 32'd0);
        chk("rst i_data", bus.i_rsp_data_o, 32'd0);
        chk("rst d_rdata", bus.d_rsp_rdata_o, 32'd0);
        chk("rst i_err", 32'(bus.i_rsp_err_o), 32'd0);
        chk("rst d_err", 32'(bus.d_rsp_err_o), 32'd0);
        rst_i = 1'b0;
        bus.i_rsp_ready_i = 1'b0; bus.d_rsp_ready_i = 1'b0;
        #1;
        chk("post-rst i_req_ready", 32'(bus.i_req_ready_o), 32'd1);
        chk("post-rst d_req_ready", 32'(bus.d_req_ready_o), 32'd1);
        bus.i_rsp_ready_i = 1'b1; bus.d_rsp_ready_i = 1'b1;
        step();

        for (int k = 0; k < 17; k++)
            d_txn(tbl[k].we, tbl[k].addr, tbl[k].be, tbl[k].wd, tbl[k].rd, tbl[k].err,
                  $sformatf("tbl%0d", k));

        // Same-cycle d write and i read of one word: i sees the old value.
        d_txn(1'b1, 32'h40, 4'hF, 32'h13, 32'h0, 1'b0, "coll init");
        bus.d_req_valid_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 32'h40;
        bus.d_be_i = 4'hF; bus.d_wdata_i = 32'h0;
        bus.i_req_valid_i = 1'b1; bus.i_addr_i = 32'h40;
        step();
        bus.d_req_valid_i = 1'b0; bus.i_req_valid_i = 1'b0;
        chk("coll i_rsp_valid", 32'(bus.i_rsp_valid_o), 32'd1);
        chk("coll i_data", bus.i_rsp_data_o, 32'h13);
        chk("coll d_rsp_valid", 32'(bus.d_rsp_valid_o), 32'd1);
        i_txn(32'h40, 32'h0, 1'b0, "coll after");

        // Instruction response stalled three cycles while the data port keeps streaming.
        d_txn(1'b1, 32'h80, 4'hF, 32'h77, 32'h0, 1'b0, "bp init0");
        d_txn(1'b1, 32'h84, 4'hF, 32'h88, 32'h0, 1'b0, "bp init1");
        bus.i_rsp_ready_i = 1'b0;
        bus.i_req_valid_i = 1'b1; bus.i_addr_i = 32'h80;
        step();
        bus.i_addr_i = 32'h84;
        bus.d_req_valid_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h84;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp i_rsp_valid", 32'(bus.i_rsp_valid_o), 32'd1);
            chk("bp i_data held", bus.i_rsp_data_o, 32'h77);
            chk("bp i_req_ready", 32'(bus.i_req_ready_o), 32'd0);
            chk("bp d_req_ready", 32'(bus.d_req_ready_o), 32'd1);
            step();
            chk("bp d_rsp_valid", 32'(bus.d_rsp_valid_o), 32'd1);
            chk("bp d_rdata", bus.d_rsp_rdata_o, 32'h88);
        end
        bus.d_req_valid_i = 1'b0;
        bus.i_rsp_ready_i = 1'b1;
        #1;
        chk("bp release i_req_ready", 32'(bus.i_req_ready_o), 32'd1);
        step();
        bus.i_req_valid_i = 1'b0;
        chk("bp second i_data", bus.i_rsp_data_o, 32'h88);
        step();
        chk("bp drain i_rsp_valid", 32'(bus.i_rsp_valid_o), 32'd0);

        // Eight back-to-back fetches yield eight responses on consecutive cycles.
        for (int k = 0; k < 8; k++)
            d_txn(1'b1, 32'(32'h200 + k * 4), 4'hF, 32'(32'hA000_0000 + k), 32'h0, 1'b0, "str init");
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                chk("str i_rsp_valid", 32'(bus.i_rsp_valid_o), 32'd1);
                chk("str i_data", bus.i_rsp_data_o, 32'(32'hA000_0000 + k - 1));
            end
            bus.i_req_valid_i = (k < 8);
            bus.i_addr_i      = 32'(32'h200 + k * 4);
            step();
        end

        // Reset while a data response is pending, with a write accepted in the reset cycle.
        d_txn(1'b1, 32'h300, 4'hF, 32'h5A5A_5A5A, 32'h0, 1'b0, "rmid init");
        bus.d_rsp_ready_i = 1'b0;
        bus.d_req_valid_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h300;
        step();
        chk("rmid pending", 32'(bus.d_rsp_valid_o), 32'd1);
        rst_i = 1'b1;
        bus.d_rsp_ready_i = 1'b1;
        bus.d_we_i = 1'b1; bus.d_be_i = 4'hF; bus.d_wdata_i = 32'hFFFF_FFFF;
        #1;
        chk("rmid d_req_ready", 32'(bus.d_req_ready_o), 32'd1);
        step();
        rst_i = 1'b0;
        bus.d_req_valid_i = 1'b0;
        chk("rmid d_rsp_valid dropped", 32'(bus.d_rsp_valid_o), 32'd0);
        d_txn(1'b0, 32'h300, 4'h0, 32'h0, 32'h5A5A_5A5A, 1'b0, "rmid readback");

        // Random traffic on both ports against an array model of the memory.
        for (int k = 0; k < 16; k++) begin
            mdl[k] = $urandom;
            d_txn(1'b1, 32'(k * 4), 4'hF, mdl[k], 32'h0, 1'b0, "rnd init");
        end
        step();
        begin
            logic        m_i_vld, m_i_err, m_d_vld, m_d_err;
            logic [31:0] m_i_dat, m_d_dat;
            logic        iv, irr, dv, dwe, drr, i_rdy, d_rdy;
            logic [31:0] ia, da, dwd, rd_i, rd_d;
            logic [3:0]  dbe;
            m_i_vld = 1'b0; m_d_vld = 1'b0;
            m_i_dat = '0; m_d_dat = '0; m_i_err = 1'b0; m_d_err = 1'b0;
            for (int c = 0; c < 400; c++) begin
                iv  = 1'($urandom_range(0, 1)); irr = ($urandom_range(0, 3) != 0);
                dv  = 1'($urandom_range(0, 1)); drr = ($urandom_range(0, 3) != 0);
                dwe = 1'($urandom_range(0, 1));
                ia  = rand_addr(); da = rand_addr();
                dbe = 4'($urandom_range(0, 15)); dwd = $urandom;
                bus.i_req_valid_i = iv; bus.i_addr_i = ia; bus.i_rsp_ready_i = irr;
                bus.d_req_valid_i = dv; bus.d_addr_i = da; bus.d_we_i = dwe;
                bus.d_be_i = dbe; bus.d_wdata_i = dwd; bus.d_rsp_ready_i = drr;
                #1;
                i_rdy = !m_i_vld || irr;
                d_rdy = !m_d_vld || drr;
                chk("rnd i_req_ready", 32'(bus.i_req_ready_o), 32'(i_rdy));
                chk("rnd d_req_ready", 32'(bus.d_req_ready_o), 32'(d_rdy));
                chk("rnd i_rsp_valid", 32'(bus.i_rsp_valid_o), 32'(m_i_vld));
                chk("rnd d_rsp_valid", 32'(bus.d_rsp_valid_o), 32'(m_d_vld));
                if (m_i_vld) begin
                    chk("rnd i_data", bus.i_rsp_data_o, m_i_dat);
                    chk("rnd i_err", 32'(bus.i_rsp_err_o), 32'(m_i_err));
                end
                if (m_d_vld) begin
                    chk("rnd d_rdata", bus.d_rsp_rdata_o, m_d_dat);
                    chk("rnd d_err", 32'(bus.d_rsp_err_o), 32'(m_d_err));
                end
                rd_i = is_fault(ia) ? 32'h0 : mdl[ia >> 2];
                rd_d = (is_fault(da) || dwe) ? 32'h0 : mdl[da >> 2];
                if (iv && i_rdy) begin
                    m_i_vld = 1'b1; m_i_dat = rd_i; m_i_err = is_fault(ia);
                end else if (irr) begin
                    m_i_vld = 1'b0;
                end
                if (dv && d_rdy) begin
                    m_d_vld = 1'b1; m_d_dat = rd_d; m_d_err = is_fault(da);
                    if (dwe && !is_fault(da)) mdl[da >> 2] = lane_merge(mdl[da >> 2], dwd, dbe);
                end else if (drr) begin
                    m_d_vld = 1'b0;
                end
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
